// File: rtl/wb_select_buffer.sv
// -----------------------------------------------------------------------------
// wb_select_buffer
//
// Write-back stage between MEM and the register file. Each cycle it picks one
// of ALU result, load data, PC+4 or immediate, extends load data according to
// funct3 (when load extension is compiled in), and queues the selected value
// together with its destination register in a small FIFO. The register file
// drains the FIFO through a valid/ready handshake.
//
// Build option:
//   LOAD_EXT_EN  - when defined, wb_sel=01 applies LB/LH/LW/LBU/LHU byte/half
//                  selection and sign/zero extension. When undefined, mem_data
//                  is stored raw and funct3/byte_off are ignored.
//   DATA_WIDTH   - parameter, default 32. Load extension assumes 32 bits.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           synchronous clear of all buffered entries (beats push/pop)
//   in_valid/ready  upstream handshake; ready = buffer not full
//   wb_sel          00 ALU, 01 MEM, 10 PC+4, 11 IMM
//   alu_result, mem_data, pc_plus4, imm   candidate write-back values
//   funct3, byte_off  load type and address[1:0] of the load
//   rd_in, reg_write  destination register and write enable of the instruction
//   out_valid/ready downstream handshake on the FIFO head
//   wb_data, wb_rd, wb_we  head entry; all zero while the buffer is empty
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. Valid never waits for ready. While the buffer is full, in_ready stays
// low for the whole cycle, even if the head is popped on the same edge.
// -----------------------------------------------------------------------------
module wb_select_buffer #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BUF_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                wb_sel,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic [DATA_WIDTH-1:0]     pc_plus4,
  input  logic [DATA_WIDTH-1:0]     imm,
  input  logic [2:0]                funct3,
  input  logic [1:0]                byte_off,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  input  logic                      reg_write,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic                      wb_we
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // ---------------------------------------------------------------------
  // Input-side selection and load extension (combinational)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] load_val;
  logic [DATA_WIDTH-1:0] sel_val;

`ifdef LOAD_EXT_EN
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    load_byte = mem_data[7:0];
    case (byte_off)
      2'd0:    load_byte = mem_data[7:0];
      2'd1:    load_byte = mem_data[15:8];
      2'd2:    load_byte = mem_data[23:16];
      default: load_byte = mem_data[31:24];
    endcase
    // Halfword loads are half-aligned, so only byte_off[1] matters.
    load_half = byte_off[1] ? mem_data[31:16] : mem_data[15:0];

    // Undefined funct3 values keep the raw word.
    load_val = mem_data;
    case (funct3)
      3'b000:  load_val = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      3'b001:  load_val = {{(DATA_WIDTH-16){load_half[15]}}, load_half};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, load_half};
      default: load_val = mem_data;
    endcase
  end
`else
  // Load type is irrelevant without extension; fold the pins away.
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{funct3, byte_off};

  always_comb begin
    load_val = mem_data;
  end
`endif

  always_comb begin
    sel_val = alu_result;
    case (wb_sel)
      SEL_ALU: sel_val = alu_result;
      SEL_MEM: sel_val = load_val;
      SEL_PC4: sel_val = pc_plus4;
      SEL_IMM: sel_val = imm;
      default: sel_val = alu_result;
    endcase
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);

  // in_ready comes from the registered count only, so a pop on a full
  // buffer cannot open a same-cycle push slot.
  assign do_push = in_valid && in_ready && !flush;
  assign do_pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      // Pointers wrap naturally because BUF_DEPTH is a power of two.
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Entry storage. Contents need no reset: every read is qualified by
  // out_valid, which comes from the reset count.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]     data_q [BUF_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] rd_q   [BUF_DEPTH];
  logic                      we_q   [BUF_DEPTH];

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_q[wr_ptr_q] <= sel_val;
      rd_q[wr_ptr_q]   <= rd_in;
      we_q[wr_ptr_q]   <= reg_write;
    end
  end

  // ---------------------------------------------------------------------
  // Head outputs, forced to zero when empty. x0 is never strobed.
  // ---------------------------------------------------------------------
  assign wb_data = out_valid ? data_q[rd_ptr_q] : '0;
  assign wb_rd   = out_valid ? rd_q[rd_ptr_q]   : '0;
  assign wb_we   = out_valid && we_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);

endmodule
